// File: rtl/rv_pkg.sv
// Shared front-end definitions: datapath widths, major opcodes, fetch buffer entry
// and the fetch unit's issue-state encoding.
package rv_pkg;

    localparam int XLEN     = 64;
    localparam int INSTR_W  = 32;
    localparam int OPCODE_W = 7;

    localparam logic [OPCODE_W-1:0] OP_RTYPE  = 7'b0110011;
    localparam logic [OPCODE_W-1:0] OP_LOAD   = 7'b0000011;
    localparam logic [OPCODE_W-1:0] OP_STORE  = 7'b0100011;
    localparam logic [OPCODE_W-1:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    // ST_DRAIN: issue is frozen until every pre-redirect response has come back.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } fetch_state_e;

    function automatic logic [OPCODE_W-1:0] opcode_of(input logic [INSTR_W-1:0] instr);
        return instr[OPCODE_W-1:0];
    endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, decode handshake
// and branch redirect. master = fetch unit, slave = memory/decode side.
interface instr_fetch_unit_if #(
    parameter int XLEN = rv_pkg::XLEN
);

    // Handshakes: a transfer happens on a rising clock edge where valid && ready.
    // valid never waits on ready, and payload stays stable while valid && !ready.
    // Responses have no ready: they are always taken, in request order.
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [31:0]     imem_rsp_data;

    logic            if_valid;
    logic            if_ready;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic [6:0]      if_opcode;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output if_valid, if_pc, if_instr, if_opcode,
        input  if_ready,
        input  redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  if_valid, if_pc, if_instr, if_opcode,
        output if_ready,
        output redirect_valid, redirect_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with flush. When empty, head keeps showing the last
// popped word so consumers see stable data while nothing is valid.
module fetch_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_q;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != (AW+1)'(DEPTH)) || do_pop);
    assign head    = (count != '0) ? mem[rd_ptr] : last_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            last_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                last_q <= mem[rd_ptr];
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues word fetches under a credit limit, buffers returned words,
// presents them to decode, and discards responses that predate a redirect.
module instr_fetch_unit
    import rv_pkg::fetch_entry_t, rv_pkg::fetch_state_e, rv_pkg::ST_RUN, rv_pkg::ST_DRAIN,
           rv_pkg::opcode_of;
#(
    parameter int              XLEN      = rv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter int              BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus,
    output fetch_state_e       state
);

    localparam int              CW         = $clog2(BUF_DEPTH) + 1;
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);
    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [XLEN-1:0] redirect_target;
    logic            epoch;
    logic [CW-1:0]   tag_count;
    logic [CW-1:0]   buf_count;
    logic [0:0]      tag_head;
    fetch_entry_t    buf_wdata;
    fetch_entry_t    buf_head;
    logic            if_valid;
    logic            pop;
    logic            req_valid;
    logic            issue;
    logic            rsp_accept;
    logic            rsp_keep;
    logic [CW:0]     credit;
    logic [CW:0]     out_next;

    // Every outstanding request owns a buffer slot; a slot being popped this cycle
    // is already free, which lets a single-cycle memory stream back-to-back.
    assign if_valid  = (buf_count != '0);
    assign pop       = if_valid && bus.if_ready;
    assign credit    = {1'b0, tag_count} + {1'b0, buf_count} - (CW+1)'(pop);
    assign req_valid = rst_n && (state == ST_RUN) && !bus.redirect_valid
                       && (credit < (CW+1)'(BUF_DEPTH));
    assign issue     = req_valid && bus.imem_req_ready;

    // A response with nothing outstanding (e.g. after reset) is ignored outright.
    assign rsp_accept = bus.imem_rsp_valid && (tag_count != '0);
    assign rsp_keep   = rsp_accept && (tag_head[0] == epoch) && (state == ST_RUN)
                        && !bus.redirect_valid;
    assign out_next   = {1'b0, tag_count} + (CW+1)'(issue) - (CW+1)'(rsp_accept);

    assign redirect_target = bus.redirect_pc & ALIGN_MASK;
    assign buf_wdata       = '{pc: rsp_pc, instr: bus.imem_rsp_data};

    fetch_fifo #(
        .WIDTH (1),
        .DEPTH (BUF_DEPTH)
    ) u_tag_q (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (issue),
        .push_data (epoch),
        .pop       (rsp_accept),
        .head      (tag_head),
        .count     (tag_count)
    );

    fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (BUF_DEPTH)
    ) u_instr_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.redirect_valid),
        .push      (rsp_keep),
        .push_data (buf_wdata),
        .pop       (pop),
        .head      (buf_head),
        .count     (buf_count)
    );

    // The 1-bit epoch can only alias if old-epoch responses survive into the next
    // redirect, so after a redirect with work in flight issue waits in ST_DRAIN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RUN;
            fetch_pc <= RESET_PC;
            rsp_pc   <= RESET_PC;
            epoch    <= 1'b0;
        end else if (bus.redirect_valid) begin
            fetch_pc <= redirect_target;
            rsp_pc   <= redirect_target;
            epoch    <= ~epoch;
            state    <= (out_next != '0) ? ST_DRAIN : ST_RUN;
        end else begin
            if (issue) begin
                fetch_pc <= fetch_pc + PC_STEP;
            end
            if (rsp_keep) begin
                rsp_pc <= rsp_pc + PC_STEP;
            end
            case (state)
                ST_RUN:   state <= ST_RUN;
                ST_DRAIN: state <= (out_next == '0) ? ST_RUN : ST_DRAIN;
                default:  state <= ST_RUN;
            endcase
        end
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = fetch_pc;
    assign bus.if_valid       = if_valid;
    assign bus.if_pc          = buf_head.pc;
    assign bus.if_instr       = buf_head.instr;
    assign bus.if_opcode      = opcode_of(buf_head.instr);

endmodule
